// File: rtl/single_clk_ram.sv
// Single-clock, single-port synchronous RAM with registered read data.
// Backs the digit-string store of the online multiplier; reset clears every word.
module single_clk_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] q,
  input  logic                  reset_n
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One register per word so the whole array clears on asynchronous reset
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mem[i] <= '0;
      end else if (we && (addr == ADDR_WIDTH'(i))) begin
        mem[i] <= data;
      end
    end
  end

  // Registered read port; a write returns the new data (write-through)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (we) begin
      q <= data;
    end else begin
      q <= mem[addr];
    end
  end

endmodule

// File: tb/tb_single_clk_ram.sv
// Self-checking bench for single_clk_ram against an array-based reference model.
module tb_single_clk_ram;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 128;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] q;

  // Reference model: plain array plus the value q should show
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_q;

  int n_checks = 0;
  int n_errors = 0;

  single_clk_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .data    (data),
    .addr    (addr),
    .we      (we),
    .clk     (clk),
    .q       (q),
    .reset_n (reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_q = '0;
  endtask

  // Drive one operation on the falling edge, clock it, update the model, check q
  task automatic op(input string tag, input logic w, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    we   = w;
    addr = AW'(a);
    data = d;
    @(posedge clk);
    if (w) begin
      ref_mem[a] = d;
      ref_q      = d;
    end else begin
      ref_q = ref_mem[a];
    end
    #1;
    check_eq(tag, q, ref_q);
  endtask

  // Assert reset between edges, check q clears immediately, release on a falling edge
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_eq(tag, q, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "_hold"}, q, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    reset_n = 1'b0;
    we      = 1'b0;
    addr    = '0;
    data    = '0;
    model_clear();
    #12;
    check_eq("por_q", q, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // Freshly reset array reads zero
    op("rd0",   1'b0, 0,   16'h0000);
    op("rd64",  1'b0, 64,  16'h0000);
    op("rd127", 1'b0, 127, 16'h0000);

    // Write-through then readback
    op("wr5", 1'b1, 5, 16'hA5C3);
    check_eq("wr5_const", q, 16'hA5C3);
    op("rd5", 1'b0, 5, 16'h0000);
    check_eq("rd5_const", q, 16'hA5C3);

    // Fill with address pattern, read back in reverse
    for (int i = 0; i < DEPTH; i++) op("fill", 1'b1, i, DW'(i));
    for (int i = DEPTH - 1; i >= 0; i--) begin
      op("rev", 1'b0, i, 16'hxxxx);
      check_eq("rev_pat", q, DW'(i));
    end

    // Read-modify-write on addr 3
    op("rmw_a", 1'b1, 3, 16'h000F);
    op("rmw_b", 1'b1, 3, 16'h00FF);
    op("rmw_rd", 1'b0, 3, 16'h0000);
    check_eq("rmw_const", q, 16'h00FF);

    // q holds while inputs change between edges
    held = q;
    @(negedge clk);
    addr = 7'd100;
    data = 16'hBEEF;
    we   = 1'b0;
    #2;
    check_eq("hold_addr", q, held);
    addr = 7'd3;
    we   = 1'b1;
    #1;
    check_eq("hold_we", q, held);
    we = 1'b0;

    // Asynchronous reset with memory loaded
    reset_pulse("rst_loaded");
    op("rd5_after_rst", 1'b0, 5, 16'h0000);
    check_eq("rd5_zero", q, 16'h0000);
    op("rd3_after_rst", 1'b0, 3, 16'h0000);

    // Reset asserted mid-write loses the write
    @(negedge clk);
    we   = 1'b1;
    addr = 7'd9;
    data = 16'h5A5A;
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_eq("midwr_q", q, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    we      = 1'b0;
    reset_n = 1'b1;
    op("midwr_rd9", 1'b0, 9, 16'h0000);

    // Reads with toggling data leave addr 7 untouched
    op("pre7", 1'b1, 7, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      op("rd7_tog", 1'b0, 7, DW'($urandom));
      check_eq("rd7_const", q, 16'h1234);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      op("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    end

    // Full sweep to catch any word the random traffic corrupted
    for (int i = 0; i < DEPTH; i++) op("sweep", 1'b0, i, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
